// File: rtl/pcs_rx_ctrl_pkg.sv
// Shared types and helpers for the PCS RX link controller.
// State encodings are visible on state_o, so they are fixed.
package pcs_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BS  = 3'd1,
    ST_WAIT_AM  = 3'd2,
    ST_WAIT_DSK = 3'd3,
    ST_UP       = 3'd4,
    ST_RESTART  = 3'd5
  } state_e;

  localparam int TIMEOUT_CYC_DEF    = 1000000;
  localparam int RESTART_CYC_DEF    = 16;
  localparam int BER_WINDOW_CYC_DEF = 195313;

  localparam int TO_W_DEF  = $clog2(TIMEOUT_CYC_DEF);
  localparam int RS_W_DEF  = $clog2(RESTART_CYC_DEF);
  localparam int WIN_W_DEF = $clog2(BER_WINDOW_CYC_DEF);

  function automatic int unsigned popcount(
    input logic [31:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++)
      n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pcs_rx_link_ctrl_ber_mon_rx.sv
// High-BER monitor: counts invalid sync headers per window
// and flags when the count reaches the threshold.
module ber_mon_rx
  import pcs_rx_ctrl_pkg::*;
#(
  parameter int LANE_N         = 4,
  parameter int BER_WINDOW_CYC = 195313,
  parameter int BER_THRESH     = 97
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [LANE_N-1:0] i_hdr_v,
  input  logic [LANE_N-1:0] i_hdr_err,
  output logic              o_hi_ber
);

  localparam int WIN_W0 = $clog2(BER_WINDOW_CYC);
  localparam int WIN_W  = (WIN_W0 < 1) ? 1 : WIN_W0;
  localparam int ERR_W  = $clog2(BER_THRESH + 1);
  localparam int unsigned TH = BER_THRESH;

  logic [WIN_W-1:0] r_win;
  logic [ERR_W-1:0] r_err;
  logic             r_hi;

  int unsigned      w_sum_i;
  logic             w_sat;
  logic [ERR_W-1:0] w_sum;
  logic             w_wrap;

  always_comb begin
    w_sum_i = 32'(r_err)
            + popcount(32'(i_hdr_v & i_hdr_err));
    w_sat   = (w_sum_i >= TH);
    w_sum   = w_sat ? ERR_W'(TH) : ERR_W'(w_sum_i);
    w_wrap  = (r_win == WIN_W'(BER_WINDOW_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
      r_err <= '0;
      r_hi  <= 1'b0;
    end else if (!i_en) begin
      r_win <= '0;
      r_err <= '0;
      r_hi  <= 1'b0;
    end else begin
      r_win <= w_wrap ? '0 : r_win + 1'b1;
      r_err <= w_wrap ? '0 : w_sum;
      // the wrap cycle's errors still count before the flag re-arms
      r_hi  <= (r_hi & ~w_wrap) | w_sat;
    end
  end

  assign o_hi_ber = r_hi;

endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// RX link bring-up FSM: block lock, AM lock, deskew, link up,
// with timeout and high-BER driven datapath restarts.
module pcs_rx_link_ctrl
  import pcs_rx_ctrl_pkg::*;
#(
  parameter int IS_10G         = 0,
  parameter int LANE_N         = (IS_10G != 0) ? 1 : 4,
  parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF,
  parameter int RESTART_CYC    = RESTART_CYC_DEF,
  parameter int BER_WINDOW_CYC = BER_WINDOW_CYC_DEF,
  parameter int BER_THRESH     = (IS_10G != 0) ? 16 : 97,
  parameter int FAIL_CNT_W     = 8
) (
  input  logic                  pcs_clk,
  input  logic                  nreset,
  input  logic [LANE_N-1:0]     bs_lock_v_i,
  input  logic [LANE_N-1:0]     am_lock_v_i,
  input  logic                  deskew_done_v_i,
  input  logic [LANE_N-1:0]     hdr_v_i,
  input  logic [LANE_N-1:0]     hdr_err_v_i,
  output logic                  restart_v_o,
  output logic                  link_up_o,
  output logic                  hi_ber_o,
  output logic [2:0]            state_o,
  output logic [FAIL_CNT_W-1:0] link_fail_cnt_o
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int RS_W  = $clog2(RESTART_CYC);
  localparam int MX_W  = (TO_W > RS_W) ? TO_W : RS_W;
  localparam int CNT_W = (MX_W < 1) ? 1 : MX_W;

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_restart;
  logic                  r_link_up;
  logic [FAIL_CNT_W-1:0] r_fail;

  state_e w_nxt;
  logic   w_bs_all;
  logic   w_am_all;
  logic   w_dsk;
  logic   w_wait;
  logic   w_timed;
  logic   w_to_hit;
  logic   w_rs_done;
  logic   w_ber_en;
  logic   w_hi_ber;

  always_comb begin
    w_bs_all  = &bs_lock_v_i;
    w_am_all  = (IS_10G != 0) ? 1'b1 : &am_lock_v_i;
    w_dsk     = (IS_10G != 0) ? 1'b1 : deskew_done_v_i;
    w_wait    = (r_state == ST_WAIT_BS)
             || (r_state == ST_WAIT_AM)
             || (r_state == ST_WAIT_DSK);
    w_timed   = w_wait || (r_state == ST_RESTART);
    w_to_hit  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    w_rs_done = (r_cnt == CNT_W'(RESTART_CYC - 1));
    w_ber_en  = w_bs_all && (r_state != ST_RESTART);
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     w_nxt = ST_WAIT_BS;
      ST_WAIT_BS:
        if (w_bs_all)
          w_nxt = (IS_10G != 0) ? ST_UP : ST_WAIT_AM;
      ST_WAIT_AM:
        if (!w_bs_all)     w_nxt = ST_WAIT_BS;
        else if (w_am_all) w_nxt = ST_WAIT_DSK;
      ST_WAIT_DSK:
        if (!w_bs_all || !w_am_all) w_nxt = ST_WAIT_BS;
        else if (w_dsk)             w_nxt = ST_UP;
      ST_UP:
        if (!w_bs_all || !w_am_all) w_nxt = ST_WAIT_BS;
        else if (w_hi_ber)          w_nxt = ST_RESTART;
      ST_RESTART:
        if (w_rs_done) w_nxt = ST_WAIT_BS;
      default:     w_nxt = ST_IDLE;
    endcase
    // a real exit in the timeout cycle beats the restart
    if (w_wait && (w_nxt == r_state) && w_to_hit)
      w_nxt = ST_RESTART;
  end

  always_ff @(posedge pcs_clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_restart <= 1'b0;
      r_link_up <= 1'b0;
      r_fail    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_restart <= (w_nxt == ST_RESTART);
      r_link_up <= (w_nxt == ST_UP);
      if ((w_nxt != r_state) || !w_timed)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if ((r_state == ST_UP) && (w_nxt != ST_UP)
          && (r_fail != {FAIL_CNT_W{1'b1}}))
        r_fail <= r_fail + 1'b1;
    end
  end

  ber_mon_rx #(
    .LANE_N         (LANE_N),
    .BER_WINDOW_CYC (BER_WINDOW_CYC),
    .BER_THRESH     (BER_THRESH)
  ) u_ber (
    .clk       (pcs_clk),
    .rst_n     (nreset),
    .i_en      (w_ber_en),
    .i_hdr_v   (hdr_v_i),
    .i_hdr_err (hdr_err_v_i),
    .o_hi_ber  (w_hi_ber)
  );

  assign restart_v_o     = r_restart;
  assign link_up_o       = r_link_up;
  assign hi_ber_o        = w_hi_ber;
  assign state_o         = r_state;
  assign link_fail_cnt_o = r_fail;

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Randomized and directed bench for pcs_rx_link_ctrl against
// a behavioural link/BER model; a 10G instance is checked too.
module tb_pcs_rx_link_ctrl;

  localparam int TO  = 64;
  localparam int RC  = 8;
  localparam int WIN = 32;
  localparam int TH  = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       nreset;
  logic [3:0] bs, am, hv, he;
  logic       dsk;
  logic       restart_v, link_up, hi_ber;
  logic [2:0] st;
  logic [7:0] fail;

  logic       nreset10;
  logic       bs10, am10, dsk10, hv10, he10;
  logic       restart10, link_up10, hi_ber10;
  logic [2:0] st10;
  logic [7:0] fail10;

  pcs_rx_link_ctrl #(
    .IS_10G(0), .LANE_N(4), .TIMEOUT_CYC(TO),
    .RESTART_CYC(RC), .BER_WINDOW_CYC(WIN),
    .BER_THRESH(TH), .FAIL_CNT_W(8)
  ) u_dut (
    .pcs_clk(clk), .nreset(nreset),
    .bs_lock_v_i(bs), .am_lock_v_i(am),
    .deskew_done_v_i(dsk),
    .hdr_v_i(hv), .hdr_err_v_i(he),
    .restart_v_o(restart_v), .link_up_o(link_up),
    .hi_ber_o(hi_ber), .state_o(st),
    .link_fail_cnt_o(fail)
  );

  pcs_rx_link_ctrl #(
    .IS_10G(1), .LANE_N(1), .TIMEOUT_CYC(TO),
    .RESTART_CYC(RC), .BER_WINDOW_CYC(WIN),
    .BER_THRESH(TH), .FAIL_CNT_W(8)
  ) u_dut10 (
    .pcs_clk(clk), .nreset(nreset10),
    .bs_lock_v_i(bs10), .am_lock_v_i(am10),
    .deskew_done_v_i(dsk10),
    .hdr_v_i(hv10), .hdr_err_v_i(he10),
    .restart_v_o(restart10), .link_up_o(link_up10),
    .hi_ber_o(hi_ber10), .state_o(st10),
    .link_fail_cnt_o(fail10)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // model: link state per the bring-up rules, time in state,
  // BER window position, errors seen this window
  int m_state, m_cnt, m_win, m_err, m_fail;
  bit m_hi;

  function automatic int popc(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic m_reset();
    m_state = 0; m_cnt = 0; m_win = 0;
    m_err = 0; m_fail = 0; m_hi = 0;
  endtask

  task automatic m_step();
    bit ba, aa, en, wrap;
    int nx, s;
    ba = (bs == 4'hf);
    aa = (am == 4'hf);
    nx = m_state;
    case (m_state)
      0: nx = 1;
      1: if (ba) nx = 2;
      2: if (!ba) nx = 1; else if (aa) nx = 3;
      3: if (!ba || !aa) nx = 1; else if (dsk) nx = 4;
      4: if (!ba || !aa) nx = 1; else if (m_hi) nx = 5;
      5: if (m_cnt >= RC - 1) nx = 1;
      default: nx = 0;
    endcase
    if (m_state >= 1 && m_state <= 3 && nx == m_state
        && m_cnt >= TO - 1)
      nx = 5;
    en = ba && (m_state != 5);
    if (!en) begin
      m_win = 0; m_err = 0; m_hi = 0;
    end else begin
      s = m_err + popc(hv & he);
      if (s > TH) s = TH;
      wrap = (m_win == WIN - 1);
      m_hi  = (wrap ? 1'b0 : m_hi) | (s >= TH);
      m_err = wrap ? 0 : s;
      m_win = wrap ? 0 : m_win + 1;
    end
    if (m_state == 4 && nx != 4 && m_fail < 255) m_fail++;
    m_cnt = (nx != m_state) ? 0 : m_cnt + 1;
    m_state = nx;
  endtask

  task automatic cmp_all();
    chk("state", int'(st), m_state);
    chk("link_up", int'(link_up), int'(m_state == 4));
    chk("restart", int'(restart_v), int'(m_state == 5));
    chk("hi_ber", int'(hi_ber), int'(m_hi));
    chk("fail_cnt", int'(fail), m_fail);
  endtask

  task automatic cyc(input logic [3:0] b, input logic [3:0] a,
                     input logic d, input logic [3:0] v,
                     input logic [3:0] e);
    bs = b; am = a; dsk = d; hv = v; he = e;
    m_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic lock_cyc();
    cyc(4'hf, 4'hf, 1'b1, 4'h0, 4'h0);
  endtask

  task automatic relock();
    int k = 0;
    while (int'(st) != 4 && k < 40) begin
      lock_cyc();
      k++;
    end
    chk("relock_up", int'(st), 4);
  endtask

  task automatic align_win(input int w);
    int k = 0;
    while (m_win != w && k < 40) begin
      lock_cyc();
      k++;
    end
    chk("win_align", m_win, w);
  endtask

  int q_st[$];
  int n_rs, n_wbs, after_rs;
  bit seen_rs, done_rs;
  logic [3:0] rb, ra, rv, re;
  bit good;

  initial begin
    nreset = 1'b0; nreset10 = 1'b0;
    bs = '0; am = '0; dsk = 1'b0; hv = '0; he = '0;
    bs10 = 1'b0; am10 = 1'b0; dsk10 = 1'b0;
    hv10 = 1'b0; he10 = 1'b0;
    m_reset();
    #22;
    chk("rst_state", int'(st), 0);
    chk("rst_restart", int'(restart_v), 0);
    chk("rst_link_up", int'(link_up), 0);
    chk("rst_hi_ber", int'(hi_ber), 0);
    chk("rst_fail", int'(fail), 0);
    @(posedge clk); #1;
    nreset = 1'b1;

    // bring-up: bs at 5, am at 10, deskew at 15
    seen_rs = 0;
    for (int i = 0; i < 20; i++) begin
      cyc((i >= 5) ? 4'hf : 4'h0, (i >= 10) ? 4'hf : 4'h0,
          (i >= 15), 4'h0, 4'h0);
      if (q_st.size() == 0 || q_st[$] != int'(st))
        q_st.push_back(int'(st));
      if (restart_v) seen_rs = 1;
    end
    chk("t1_nstates", q_st.size(), 4);
    for (int i = 0; i < 4 && i < q_st.size(); i++)
      chk("t1_order", q_st[i], i + 1);
    chk("t1_up", int'(link_up), 1);
    chk("t1_no_restart", int'(seen_rs), 0);

    // single-cycle lock loss on lane 2
    cyc(4'b1011, 4'hf, 1'b1, 4'h0, 4'h0);
    chk("t3_state", int'(st), 1);
    chk("t3_link_up", int'(link_up), 0);
    chk("t3_fail", int'(fail), 1);
    relock();

    // high BER: lanes 0,1 at window cycles 3 and 4
    align_win(3);
    cyc(4'hf, 4'hf, 1'b1, 4'h3, 4'h3);
    cyc(4'hf, 4'hf, 1'b1, 4'h3, 4'h3);
    chk("t4_hi_set", int'(hi_ber), 1);
    lock_cyc();
    chk("t4_restart", int'(st), 5);
    lock_cyc();
    chk("t4_hi_clr", int'(hi_ber), 0);
    relock();

    // 3 errors per window never reach threshold
    align_win(5);
    for (int i = 0; i < 3; i++)
      cyc(4'hf, 4'hf, 1'b1, 4'h1, 4'h1);
    lock_cyc();
    align_win(5);
    chk("t5_hi_w1", int'(hi_ber), 0);
    for (int i = 0; i < 3; i++)
      cyc(4'hf, 4'hf, 1'b1, 4'h1, 4'hf);
    lock_cyc();
    chk("t5_hi_w2", int'(hi_ber), 0);
    chk("t5_up", int'(st), 4);

    // timeout: lane 3 never locks
    n_rs = 0; n_wbs = 0; after_rs = -1;
    seen_rs = 0; done_rs = 0;
    for (int i = 0; i < 90; i++) begin
      cyc(4'b0111, 4'hf, 1'b1, 4'h0, 4'h0);
      if (restart_v) begin
        n_rs++; seen_rs = 1;
      end else if (seen_rs && !done_rs) begin
        after_rs = int'(st); done_rs = 1;
      end
      if (!seen_rs && int'(st) == 1) n_wbs++;
    end
    chk("t2_wait_len", n_wbs, TO);
    chk("t2_rs_len", n_rs, RC);
    chk("t2_after", after_rs, 1);
    relock();

    // 10G instance: straight to UP, AM/deskew ignored
    nreset10 = 1'b1;
    am10 = 1'b0; dsk10 = 1'b0;
    lock_cyc();
    chk("g_wait_bs", int'(st10), 1);
    lock_cyc();
    lock_cyc();
    chk("g_still_wait", int'(st10), 1);
    bs10 = 1'b1;
    lock_cyc();
    chk("g_up", int'(st10), 4);
    chk("g_link_up", int'(link_up10), 1);
    am10 = 1'b1;
    lock_cyc();
    am10 = 1'b0;
    lock_cyc();
    chk("g_up_hold", int'(st10), 4);
    #2 nreset10 = 1'b0;
    #1;
    chk("g_rst_state", int'(st10), 0);
    chk("g_rst_link_up", int'(link_up10), 0);
    chk("g_rst_restart", int'(restart10), 0);
    chk("g_rst_hi", int'(hi_ber10), 0);
    chk("g_rst_fail", int'(fail10), 0);

    // randomized segments of near-locked and noisy inputs
    good = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) good = ($urandom_range(0, 3) != 0);
      if (good) begin
        rb = ($urandom_range(0, 47) == 0)
           ? (4'hf ^ (4'h1 << $urandom_range(0, 3))) : 4'hf;
        ra = ($urandom_range(0, 47) == 0) ? 4'h7 : 4'hf;
      end else begin
        rb = 4'($urandom);
        ra = 4'($urandom);
      end
      rv = 4'($urandom);
      re = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      cyc(rb, ra, ($urandom_range(0, 7) != 0), rv, re);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
